mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle sequencing FSM for the 16-bit, 4-register MIPS CPU (reg_file + alu datapath).
//  Replaces the single-cycle MainControl: fetches over an imem req/ack handshake, then steps
//  DECODE/EXECUTE/WRITEBACK, driving register-file, ALU and PC/IR/A-B/ALUOut write strobes.
//  Adds HALT, illegal-opcode and fetch-timeout traps, and a retired-instruction counter.
// PARAMETERS
//  IMEM_TIMEOUT  15  max FETCH wait cycles without imem_ack before fetch-timeout trap (>=1)
//  CNT_WIDTH     16  width of retired-instruction counter
// PORTS
//  clock       in   1          system clock, all state updates on posedge
//  reset_n     in   1          asynchronous, active-low reset
//  run         in   1          level; 1 = keep executing, 0 = stop after current instruction
//  imem_ack    in   1          instruction memory: ir_in valid this cycle
//  ir_in       in   16         instruction word from memory (opcode = ir_in[15:12])
//  imem_req    out  1          fetch request, held high in FETCH until ack
//  pc_write    out  1          PC <= PC+2 strobe
//  ir_write    out  1          IR <= ir_in strobe
//  ab_write    out  1          A/B operand latch strobe (reg_file rd1/rd2)
//  out_write   out  1          ALUOut latch strobe
//  reg_write   out  1          reg_file regwrite
//  reg_dst     out  1          1: wr = IR[7:6] (R-type); 0: wr = IR[9:8] (ADDI)
//  alu_src     out  1          1: B = sign-extended IR[7:0]; 0: B = rd2
//  alu_ctl     out  3          alu op: AND 000, OR 001, ADD 010, SUB 110, SLT 111
//  busy        out  1          1 in any state except IDLE and TRAP
//  halted      out  1          sticky; set by HALT, cleared on IDLE->FETCH
//  trap        out  1          1 in TRAP state
//  trap_cause  out  2          00 none, 01 illegal opcode, 10 fetch timeout
//  retired     out  CNT_WIDTH  count of completed WRITEBACKs, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; every output 0; timeout count and retired = 0.
//  - States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
//  - IDLE: strobes 0. run=1 sampled -> FETCH, halted cleared on this transition.
//  - FETCH: imem_req=1 (Moore). ir_write=pc_write = imem_ack (same cycle, Mealy); on ack -> DECODE.
//    Wait counter +1 per no-ack cycle; no ack on cycle IMEM_TIMEOUT+1 -> TRAP, cause 10.
//    Ack on the final allowed cycle wins over timeout. Counter clears on leaving FETCH.
//  - DECODE: opcode taken from the IR register (loaded at the FETCH exit edge); ab_write=1.
//    Opcode 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0111 SLT: R-type (reg_dst=1, alu_src=0).
//    0100 ADDI (reg_dst=0, alu_src=1, alu_ctl=010). 1111 HALT: halted=1 -> IDLE, no retire.
//    Other opcodes -> TRAP, cause 01. Decoded fields registered, valid from EXECUTE.
//  - EXECUTE: out_write=1; reg_dst/alu_src/alu_ctl driven -> WRITEBACK.
//  - WRITEBACK: reg_write=1, same decoded fields held; retired+1;
//    next = FETCH if run=1 else IDLE.
//  - reg_dst/alu_src/alu_ctl are 0 outside EXECUTE/WRITEBACK. Every strobe is a 1-cycle pulse.
//  - Zero-wait memory: 4 cycles per instruction. HALT costs 2 cycles.
//  - run=0 mid-instruction: the current instruction completes, then IDLE. run is ignored
//    in TRAP.
//  - TRAP: all strobes 0, trap=1, cause held; only reset exits.
//  - retired wraps all-ones -> 0 with no flag.
// TESTING
//  1 Reset + run=1, ack each req, program ADDI $1,15 (410F) -> 4-cycle cadence, strobes in
//    order ir/pc, ab, out, reg; reg_dst=0, alu_src=1, alu_ctl=010; retired=1.
//  2 8-instr program (ADDI, ADDI, AND, SUB, OR, ADD, SLT, SLT) -> alu_ctl 010,010,000,110,001,
//    010,111,111; reg_write x8; retired=8 after 32 cycles.
//  3 ack delayed 15 cycles -> no trap; delayed 16 -> trap=1, cause=10, imem_req=0, strobes silent.
//  4 opcode 0101 -> TRAP cause 01 after DECODE, retired unchanged. Opcode F000 -> halted=1,
//    IDLE, busy=0. Next run=1 clears halted.
//  5 run dropped during EXECUTE -> reg_write still pulses, then IDLE. Reset_n low in EXECUTE ->
//    outputs 0 immediately, no reg_write.
//  6 CNT_WIDTH=4, 17 instructions -> retired=1 (wrap).

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencing FSM for the 16-bit, 4-register MIPS CPU.
// Sequence: IDLE -> FETCH (imem req/ack) -> DECODE -> EXECUTE -> WRITEBACK -> FETCH/IDLE.
// HALT returns to IDLE with a sticky flag; illegal opcodes and fetch timeouts park in TRAP
// until reset. All outputs are registered except ir_write/pc_write, which follow imem_ack
// combinationally while fetching.
module mips_multicycle_ctrl #(
    parameter int unsigned IMEM_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 imem_ack,
    input  logic [15:0]          ir_in,
    output logic                 imem_req,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 ab_write,
    output logic                 out_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 alu_src,
    output logic [2:0]           alu_ctl,
    output logic                 busy,
    output logic                 halted,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int unsigned WaitW = $clog2(IMEM_TIMEOUT + 1);

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StTrap
    } state_e;

    state_e           state;
    logic [3:0]       opcode;
    logic [WaitW-1:0] wait_cnt;

    logic             dec_legal;
    logic             dec_halt;
    logic             dec_rtype;
    logic [2:0]       dec_ctl;

    // Only the opcode field matters to the controller; operand fields go to the datapath.
    logic unused_ir;
    assign unused_ir = ^ir_in[11:0];

    // imem_req is high exactly while in FETCH, so it gates the Mealy IR/PC strobes.
    assign ir_write = imem_req & imem_ack;
    assign pc_write = imem_req & imem_ack;

    // Opcode decode from the latched IR opcode.
    always_comb begin
        dec_legal = 1'b0;
        dec_halt  = 1'b0;
        dec_rtype = 1'b0;
        dec_ctl   = AluAnd;
        case (opcode)
            4'h0: begin dec_legal = 1'b1; dec_rtype = 1'b1; dec_ctl = AluAdd; end
            4'h1: begin dec_legal = 1'b1; dec_rtype = 1'b1; dec_ctl = AluSub; end
            4'h2: begin dec_legal = 1'b1; dec_rtype = 1'b1; dec_ctl = AluAnd; end
            4'h3: begin dec_legal = 1'b1; dec_rtype = 1'b1; dec_ctl = AluOr;  end
            4'h7: begin dec_legal = 1'b1; dec_rtype = 1'b1; dec_ctl = AluSlt; end
            4'h4: begin dec_legal = 1'b1; dec_rtype = 1'b0; dec_ctl = AluAdd; end
            4'hF: dec_halt = 1'b1;
            default: ;
        endcase
    end

    // State sequencing with registered outputs set on entry to each state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            opcode     <= 4'h0;
            wait_cnt   <= '0;
            imem_req   <= 1'b0;
            ab_write   <= 1'b0;
            out_write  <= 1'b0;
            reg_write  <= 1'b0;
            reg_dst    <= 1'b0;
            alu_src    <= 1'b0;
            alu_ctl    <= 3'b000;
            busy       <= 1'b0;
            halted     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 2'b00;
            retired    <= '0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            ab_write  <= 1'b0;
            out_write <= 1'b0;
            reg_write <= 1'b0;
            case (state)
                StIdle: begin
                    if (run) begin
                        state    <= StFetch;
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                StFetch: begin
                    // An ack on the last allowed cycle takes priority over the timeout.
                    if (imem_ack) begin
                        state    <= StDecode;
                        opcode   <= ir_in[15:12];
                        imem_req <= 1'b0;
                        ab_write <= 1'b1;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WaitW'(IMEM_TIMEOUT)) begin
                        state      <= StTrap;
                        imem_req   <= 1'b0;
                        busy       <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= 2'b10;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WaitW'(1);
                    end
                end
                StDecode: begin
                    if (dec_legal) begin
                        state     <= StExecute;
                        out_write <= 1'b1;
                        reg_dst   <= dec_rtype;
                        alu_src   <= ~dec_rtype;
                        alu_ctl   <= dec_ctl;
                    end else if (dec_halt) begin
                        state  <= StIdle;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state      <= StTrap;
                        trap       <= 1'b1;
                        trap_cause <= 2'b01;
                        busy       <= 1'b0;
                    end
                end
                StExecute: begin
                    state     <= StWriteback;
                    reg_write <= 1'b1;
                end
                StWriteback: begin
                    retired <= retired + CNT_WIDTH'(1);
                    reg_dst <= 1'b0;
                    alu_src <= 1'b0;
                    alu_ctl <= 3'b000;
                    if (run) begin
                        state    <= StFetch;
                        imem_req <= 1'b1;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StTrap: ;
                default: begin
                    state    <= StIdle;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: a 16-bit-counter instance plus a 4-bit-counter instance
// sharing stimulus. Expected WRITEBACK fields are queued at fetch and checked at reg_write.
module tb_mips_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        run;
    logic        imem_ack;
    logic [15:0] ir_in;

    logic        imem_req, pc_write, ir_write, ab_write, out_write, reg_write;
    logic        reg_dst, alu_src, busy, halted, trap;
    logic [2:0]  alu_ctl;
    logic [1:0]  trap_cause;
    logic [15:0] retired;

    logic        imem_req4, pc_write4, ir_write4, ab_write4, out_write4, reg_write4;
    logic        reg_dst4, alu_src4, busy4, halted4, trap4;
    logic [2:0]  alu_ctl4;
    logic [1:0]  trap_cause4;
    logic [3:0]  retired4;

    mips_multicycle_ctrl #(.IMEM_TIMEOUT(15), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .imem_ack(imem_ack), .ir_in(ir_in),
        .imem_req(imem_req), .pc_write(pc_write), .ir_write(ir_write), .ab_write(ab_write),
        .out_write(out_write), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .alu_ctl(alu_ctl), .busy(busy), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    mips_multicycle_ctrl #(.IMEM_TIMEOUT(15), .CNT_WIDTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .run(run), .imem_ack(imem_ack), .ir_in(ir_in),
        .imem_req(imem_req4), .pc_write(pc_write4), .ir_write(ir_write4),
        .ab_write(ab_write4), .out_write(out_write4), .reg_write(reg_write4),
        .reg_dst(reg_dst4), .alu_src(alu_src4), .alu_ctl(alu_ctl4), .busy(busy4),
        .halted(halted4), .trap(trap4), .trap_cause(trap_cause4), .retired(retired4)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] ctl;
        logic       dst;
        logic       src;
    } exp_t;

    exp_t sb_q[$];
    exp_t popped;
    int   checks = 0;
    int   failures = 0;
    int   exp_retired = 0;
    int   cyc = 0;
    int   last_ack_cyc = 0;

    logic [15:0] prog [8] = '{16'h4105, 16'h4203, 16'h2640, 16'h1680,
                              16'h36C0, 16'h0640, 16'h7640, 16'h7980};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected decoded fields for a legal ALU opcode.
    function automatic exp_t exp_of(input logic [3:0] op);
        case (op)
            4'h0:    return {3'b010, 1'b1, 1'b0};
            4'h1:    return {3'b110, 1'b1, 1'b0};
            4'h2:    return {3'b000, 1'b1, 1'b0};
            4'h3:    return {3'b001, 1'b1, 1'b0};
            4'h7:    return {3'b111, 1'b1, 1'b0};
            default: return {3'b010, 1'b0, 1'b1};
        endcase
    endfunction

    // Scoreboard consumer: every reg_write pulse must match the oldest queued instruction.
    always @(negedge clock) begin
        if (!reset_n) begin
            check_eq("rw_in_reset", 32'(reg_write), 0);
            sb_q.delete();
            exp_retired = 0;
        end else if (reg_write) begin
            if (sb_q.size() == 0) begin
                check_eq("rw_unexpected", 32'(reg_write), 0);
            end else begin
                popped = sb_q.pop_front();
                check_eq("wb_alu_ctl", 32'(alu_ctl), 32'(popped.ctl));
                check_eq("wb_reg_dst", 32'(reg_dst), 32'(popped.dst));
                check_eq("wb_alu_src", 32'(alu_src), 32'(popped.src));
                check_eq("wb_retired", 32'(retired), 32'(exp_retired % 65536));
                check_eq("wb_retired4", 32'(retired4), 32'(exp_retired % 16));
                exp_retired = exp_retired + 1;
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Serve one fetch after 'delay' no-ack cycles; optionally queue its expected writeback.
    task automatic fetch(input logic [15:0] instr, input int delay, input bit push,
                         input bit gap);
        wait_req();
        if (imem_req !== 1'b1) begin
            check_eq("req_wait", 32'(imem_req), 1);
            return;
        end
        for (int d = 0; d < delay; d++) begin
            check_eq("ir_write_idle", 32'(ir_write), 0);
            @(negedge clock);
        end
        imem_ack = 1'b1;
        ir_in    = instr;
        #1;
        check_eq("ir_write", 32'(ir_write), 1);
        check_eq("pc_write", 32'(pc_write), 1);
        if (push) sb_q.push_back(exp_of(instr[15:12]));
        if (gap) check_eq("cadence", 32'(cyc - last_ack_cyc), 4);
        last_ack_cyc = cyc;
        @(posedge clock);
        #1;
        imem_ack = 1'b0;
        ir_in    = 16'h0000;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        check_eq("idle_reached", 32'(busy), 0);
    endtask

    // Assert reset at a negedge, check outputs clear at once, release a cycle later.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_eq("rst_imem_req", 32'(imem_req), 0);
        check_eq("rst_strobes", 32'({ab_write, out_write, reg_write, ir_write, pc_write}), 0);
        check_eq("rst_fields", 32'({reg_dst, alu_src, alu_ctl}), 0);
        check_eq("rst_status", 32'({busy, halted, trap, trap_cause}), 0);
        check_eq("rst_retired", 32'(retired), 0);
        @(negedge clock);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        run      = 1'b0;
        imem_ack = 1'b0;
        ir_in    = 16'h0000;
        @(negedge clock);
        do_reset();
        @(negedge clock);
        check_eq("idle_busy", 32'(busy), 0);

        // ADDI with cycle-by-cycle strobe order
        run = 1'b1;
        fetch(16'h410F, 0, 1'b1, 1'b0);
        @(negedge clock);
        check_eq("dec_ab_write", 32'(ab_write), 1);
        check_eq("dec_others", 32'({out_write, reg_write, ir_write, imem_req}), 0);
        check_eq("dec_busy", 32'(busy), 1);
        @(negedge clock);
        check_eq("ex_out_write", 32'(out_write), 1);
        check_eq("ex_ab_write", 32'(ab_write), 0);
        check_eq("ex_fields", 32'({reg_dst, alu_src, alu_ctl}), 32'({1'b0, 1'b1, 3'b010}));
        @(negedge clock);
        check_eq("wb_reg_write", 32'(reg_write), 1);
        check_eq("wb_out_write", 32'(out_write), 0);

        // Eight-instruction program back to back
        for (int i = 0; i < 8; i++) fetch(prog[i], 0, 1'b1, 1'b1);
        run = 1'b0;
        wait_idle();
        check_eq("prog_retired", 32'(retired), 32'(exp_retired));
        check_eq("prog_sb_empty", 32'(sb_q.size()), 0);
        check_eq("prog_imem_req", 32'(imem_req), 0);

        // Fetch wait 15 succeeds, wait 16 traps
        run = 1'b1;
        fetch(16'h4101, 15, 1'b1, 1'b0);
        wait_req();
        for (int d = 0; d < 16; d++) begin
            check_eq("to_no_trap", 32'(trap), 0);
            @(negedge clock);
        end
        check_eq("to_trap", 32'(trap), 1);
        check_eq("to_cause", 32'(trap_cause), 2);
        check_eq("to_imem_req", 32'(imem_req), 0);
        check_eq("to_busy", 32'(busy), 0);
        run      = 1'b0;
        imem_ack = 1'b1;
        for (int d = 0; d < 3; d++) begin
            #1;
            check_eq("trap_ir_write", 32'(ir_write), 0);
            check_eq("trap_strobes", 32'({pc_write, ab_write, out_write, reg_write}), 0);
            @(negedge clock);
        end
        imem_ack = 1'b0;
        run      = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_eq("trap_held", 32'({trap, trap_cause}), 32'({1'b1, 2'b10}));
        check_eq("trap_retired", 32'(retired), 32'(exp_retired));
        run = 1'b0;
        do_reset();

        // Illegal opcode
        run = 1'b1;
        fetch(16'h5000, 0, 1'b0, 1'b0);
        @(negedge clock);
        check_eq("ill_ab_write", 32'(ab_write), 1);
        @(negedge clock);
        check_eq("ill_trap", 32'({trap, trap_cause}), 32'({1'b1, 2'b01}));
        check_eq("ill_busy", 32'(busy), 0);
        check_eq("ill_out_write", 32'(out_write), 0);
        check_eq("ill_retired", 32'(retired), 32'(exp_retired));
        run = 1'b0;
        do_reset();

        // HALT then resume
        run = 1'b1;
        fetch(16'hF000, 0, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check_eq("halt_halted", 32'(halted), 1);
        check_eq("halt_busy", 32'(busy), 0);
        check_eq("halt_imem_req", 32'(imem_req), 0);
        check_eq("halt_retired", 32'(retired), 0);
        @(negedge clock);
        check_eq("resume_halted", 32'(halted), 0);
        check_eq("resume_req", 32'({busy, imem_req}), 32'(2'b11));

        // run dropped during EXECUTE
        fetch(16'h0190, 0, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check_eq("rd_ex_fields", 32'({reg_dst, alu_src, alu_ctl}), 32'({1'b1, 1'b0, 3'b010}));
        run = 1'b0;
        @(negedge clock);
        check_eq("rd_reg_write", 32'(reg_write), 1);
        @(negedge clock);
        check_eq("rd_idle", 32'({busy, imem_req}), 0);
        check_eq("rd_fields_clr", 32'({reg_dst, alu_src, alu_ctl}), 0);
        check_eq("rd_retired", 32'(retired), 32'(exp_retired));

        // Reset during EXECUTE
        run = 1'b1;
        fetch(16'h3000, 0, 1'b0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check_eq("rx_out_write", 32'(out_write), 1);
        run = 1'b0;
        do_reset();

        // Counter wrap on the 4-bit instance
        run = 1'b1;
        for (int i = 0; i < 17; i++) fetch(prog[i % 8], 0, 1'b1, i > 0);
        run = 1'b0;
        wait_idle();
        check_eq("wrap_retired", 32'(retired), 17);
        check_eq("wrap_retired4", 32'(retired4), 1);
        check_eq("wrap_sb_empty", 32'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
